// File: rtl/tfe_pkg.sv
// tfe_pkg: shared types, widths and byte selection for the result byte serializer
package tfe_pkg;
    typedef enum logic {IDLE, SEND} ser_state_t;
    localparam int BYTE_W = 8;
    localparam int MAX_W = 1024;
    // Returns byte idx of shadow counted from the MSB end (msb_first) or the LSB end.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [MAX_W-1:0] shadow, input int idx,
                                                   input int num_bytes, input logic msb_first);
        int pos;
        pos = msb_first ? num_bytes - 1 - idx : idx;
        return shadow[pos*BYTE_W +: BYTE_W];
    endfunction
endpackage

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: one-cycle pulse on each rising edge of a level input
// Ports: clk, rst (sync, active-high), in (level), rise (pulse).
// The delay flop follows in even during reset, so a level held high across
// reset release is not seen as an edge.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic in_d_q, in_d_d;
    always_comb in_d_d = in;
    always_ff @(posedge clk) in_d_q <= in_d_d;
    assign rise = in & ~in_d_q & ~rst;
endmodule

// File: rtl/result_byte_serializer.sv
// result_byte_serializer: captures a wide result and streams it out one byte per host read strobe
// Ports: clk, rst (sync, active-high); load + result_in capture a frame; next rising
// edges consume bytes; clear drops the overrun flag. Outputs out_byte/out_valid/out_last
// present the stream, busy mirrors out_valid, frame_done pulses after the final byte,
// overrun is sticky when a load is dropped.
module result_byte_serializer
    import tfe_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter bit MSB_FIRST   = 1,
    parameter bit CHECKSUM_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] result_in,
    input  logic              next,
    input  logic              clear,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);
    localparam int NUM_BYTES = DATA_W / BYTE_W;
    localparam int FRAME_LEN = NUM_BYTES + int'(CHECKSUM_EN);
    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_BYTES);
    ser_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [7:0] csum_q, csum_d, out_byte_q, out_byte_d, load_csum;
    logic frame_done_q, frame_done_d, overrun_q, overrun_d;
    logic next_rise, sending, last_consume, accept;
    rise_edge_detect u_next_edge (.clk(clk), .rst(rst), .in(next), .rise(next_rise));
    always_comb begin
        load_csum = '0;
        for (int i = 0; i < NUM_BYTES; i++) load_csum ^= result_in[i*BYTE_W +: BYTE_W];
    end
    assign sending = state_q == SEND;
    assign last_consume = sending & next_rise & (idx_q == LAST_IDX);
    // A load is taken when idle or when it lands on the edge that frees the frame.
    assign accept = load & (~sending | last_consume);
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        shadow_d = shadow_q;
        csum_d = csum_q;
        frame_done_d = last_consume;
        overrun_d = (overrun_q & ~clear) | (load & ~accept);
        if (sending & next_rise) idx_d = idx_q + IDX_W'(1);
        if (last_consume) state_d = IDLE;
        if (accept) begin
            state_d = SEND;
            idx_d = '0;
            shadow_d = result_in;
            csum_d = load_csum;
        end
        // Registered byte mux; in IDLE the last presented byte is held.
        out_byte_d = state_d != SEND ? out_byte_q :
                     idx_d == CSUM_IDX ? csum_d :
                     byte_sel(MAX_W'(shadow_d), int'(idx_d), NUM_BYTES, MSB_FIRST);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            shadow_q <= '0;
            csum_q <= '0;
            out_byte_q <= '0;
            frame_done_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            shadow_q <= shadow_d;
            csum_q <= csum_d;
            out_byte_q <= out_byte_d;
            frame_done_q <= frame_done_d;
            overrun_q <= overrun_d;
        end
    end
    assign out_byte = out_byte_q;
    assign out_valid = sending;
    assign busy = sending;
    assign out_last = sending & (idx_q == LAST_IDX);
    assign frame_done = frame_done_q;
    assign overrun = overrun_q;
endmodule
